// File: rtl/deserializer.sv
// Serial-to-parallel word recovery.
//
// A contiguous run of ser_data_val_i=1 cycles forms one word, collected MSB-first
// into a left-aligned shift register. A run that reaches DATA_W bits is emitted on
// the edge that samples its last bit. A run that stops early is emitted on the
// first idle edge if it holds at least 3 bits, and is silently dropped if it holds
// 1 or 2 bits. Every emitted word is qualified by a one-cycle deser_data_val_o strobe.
//
// Ports:
//   clk_i            - clock, rising-edge active
//   arst_n_i         - asynchronous active-low reset
//   ser_data_i       - serial data bit
//   ser_data_val_i   - qualifies ser_data_i
//   deser_data_o     - recovered word, MSB-first, left-aligned, unused LSBs zero
//   deser_data_mod_o - valid bit count of deser_data_o (0 means DATA_W bits)
//   deser_data_val_o - one-cycle strobe for deser_data_o / deser_data_mod_o
//   busy_o           - high while a word is being collected
//
// DATA_W is expected to be a power of two, at least 4, so that every partial
// count (3..DATA_W-1) fits in MOD_W bits.

module deserializer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  output logic              busy_o
);

  // cnt spans 0..DATA_W
  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam int unsigned IdxW = $clog2(DATA_W);

  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] MinCnt  = CntW'(3);
  localparam logic [IdxW-1:0] TopIdx  = IdxW'(DATA_W - 1);

  typedef enum logic [0:0] {
    StIdle,
    StRecv
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [MOD_W-1:0]  mod_q, mod_d;
  logic              val_q, val_d;
  logic [IdxW-1:0]   bit_idx;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ser_data_val_i) state_d = StRecv;
      end
      StRecv: begin
        // Leave on a gap, or on the bit that fills the word.
        if (!ser_data_val_i || (cnt_q == LastCnt)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o = (state_q == StRecv);
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    // cnt bits already stored, so the next bit lands cnt places below the MSB.
    bit_idx = TopIdx - IdxW'(cnt_q);

    unique case (state_q)
      StIdle: begin
        if (ser_data_val_i) begin
          // Start of a word: drop whatever the previous word left behind.
          shreg_d             = '0;
          shreg_d[DATA_W-1]   = ser_data_i;
          cnt_d               = CntW'(1);
        end
      end
      StRecv: begin
        if (ser_data_val_i) begin
          shreg_d[bit_idx] = ser_data_i;
          if (cnt_q == LastCnt) begin
            // Full word: emit including the bit sampled on this edge.
            data_d = shreg_d;
            mod_d  = '0;
            val_d  = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          // Gap ends the run; runs of 1 or 2 bits are not legal words.
          if (cnt_q >= MinCnt) begin
            data_d = shreg_q;
            mod_d  = cnt_q[MOD_W-1:0];
            val_d  = 1'b1;
          end
          cnt_d = '0;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
    end
  end

  assign deser_data_o     = data_q;
  assign deser_data_mod_o = mod_q;
  assign deser_data_val_o = val_q;

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: table of serial runs plus hand-written corner sequences.
// Expected words are queued when the run is driven and matched when the strobe fires.

module tb_deserializer;

  localparam int DW = 16;
  localparam int MW = 4;

  logic          clk            = 1'b0;
  logic          arst_n         = 1'b1;
  logic          ser_data       = 1'b0;
  logic          ser_data_val   = 1'b0;
  logic [DW-1:0] deser_data;
  logic [MW-1:0] deser_data_mod;
  logic          deser_data_val;
  logic          busy;

  deserializer #(
    .DATA_W(DW),
    .MOD_W (MW)
  ) dut (
    .clk_i           (clk),
    .arst_n_i        (arst_n),
    .ser_data_i      (ser_data),
    .ser_data_val_i  (ser_data_val),
    .deser_data_o    (deser_data),
    .deser_data_mod_o(deser_data_mod),
    .deser_data_val_o(deser_data_val),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [MW-1:0] mod;
    int            edge_n;
  } exp_t;

  typedef struct {
    int            len;
    logic [DW-1:0] bits;
    bit            strobe;
    logic [DW-1:0] data;
    logic [MW-1:0] mod;
  } vec_t;

  exp_t sb[$];
  exp_t got_e;
  vec_t vecs[9];

  int cyc         = 0;
  int checks      = 0;
  int passes      = 0;
  int busy_cycles = 0;
  int pushed      = 0;
  int seen        = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (busy === 1'b1) busy_cycles++;
    if (deser_data_val === 1'b1) begin
      seen++;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_strobe: got data 0x%0h mod %0d, required no strobe (cycle %0d)",
                 deser_data, deser_data_mod, cyc);
      end else begin
        got_e = sb.pop_front();
        check("strobe_data", 32'(deser_data), 32'(got_e.data));
        check("strobe_mod", 32'(deser_data_mod), 32'(got_e.mod));
        check("strobe_cycle", 32'(cyc), 32'(got_e.edge_n));
      end
    end
  end

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic drive(input logic v, input logic b);
    @(negedge clk);
    ser_data_val = v;
    ser_data     = b;
  endtask

  task automatic expect_strobe(input logic [DW-1:0] d, input logic [MW-1:0] m);
    exp_t e;
    e.data   = d;
    e.mod    = m;
    e.edge_n = cyc + 1;
    sb.push_back(e);
    pushed++;
  endtask

  task automatic run(input logic [DW-1:0] bits, input int len, input bit gap, input bit strobe,
                     input logic [DW-1:0] d, input logic [MW-1:0] m);
    for (int i = 0; i < len; i++) begin
      drive(1'b1, bits[DW-1-i]);
      if (strobe && len == DW && i == DW - 1) expect_strobe(d, m);
    end
    if (gap) begin
      drive(1'b0, 1'b0);
      if (strobe && len < DW) expect_strobe(d, m);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 32'(deser_data), 32'h0);
    check({tag, "_mod"}, 32'(deser_data_mod), 32'h0);
    check({tag, "_val"}, 32'(deser_data_val), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    //           len  bits      strobe data      mod
    vecs[0] = '{16, 16'hF0F0, 1'b1, 16'hF0F0, 4'd0};
    vecs[1] = '{5,  16'hB000, 1'b1, 16'hB000, 4'd5};
    vecs[2] = '{2,  16'hC000, 1'b0, 16'h0000, 4'd0};
    vecs[3] = '{16, 16'hA5A5, 1'b1, 16'hA5A5, 4'd0};
    vecs[4] = '{3,  16'hA000, 1'b1, 16'hA000, 4'd3};
    vecs[5] = '{15, 16'hFFFE, 1'b1, 16'hFFFE, 4'd15};
    vecs[6] = '{1,  16'h8000, 1'b0, 16'h0000, 4'd0};
    vecs[7] = '{16, 16'h0001, 1'b1, 16'h0001, 4'd0};
    vecs[8] = '{4,  16'h9000, 1'b1, 16'h9000, 4'd4};

    // Reset asserted between edges clears outputs at once.
    #1 arst_n = 1'b0;
    #1 check_all_zero("reset_init");
    repeat (2) @(negedge clk);
    arst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      run(vecs[v].bits, vecs[v].len, 1'b1, vecs[v].strobe, vecs[v].data, vecs[v].mod);
    end

    // Partial word 1,0,1,1,0: busy for exactly 5 cycles.
    busy_cycles = 0;
    run(16'hB000, 5, 1'b1, 1'b1, 16'hB000, 4'd5);
    drive(1'b0, 1'b0);
    check("busy_cycles_partial", 32'(busy_cycles), 32'd5);

    // Reset mid-word after 9 bits; outputs (B000/5) must drop before the next edge.
    run(16'hFFFF, 9, 1'b0, 1'b0, 16'h0, 4'd0);
    @(posedge clk);
    #2 arst_n = 1'b0;
    #1 check_all_zero("reset_midword");
    #1 arst_n = 1'b1;
    run(16'h1234, 16, 1'b1, 1'b1, 16'h1234, 4'd0);

    // Short run: no strobe, busy drops, next word intact.
    busy_cycles = 0;
    run(16'hC000, 2, 1'b1, 1'b0, 16'h0, 4'd0);
    @(negedge clk);
    check("short_busy_low", 32'(busy), 32'h0);
    check("short_busy_cycles", 32'(busy_cycles), 32'd2);
    run(16'h5A3C, 16, 1'b1, 1'b1, 16'h5A3C, 4'd0);

    // Back-to-back words, no gap between them.
    run(16'hA5A5, 16, 1'b0, 1'b1, 16'hA5A5, 4'd0);
    run(16'h0FF0, 16, 1'b1, 1'b1, 16'h0FF0, 4'd0);

    // Outputs hold after the strobe.
    repeat (3) drive(1'b0, 1'b0);
    check("hold_data", 32'(deser_data), 32'h0FF0);
    check("hold_mod", 32'(deser_data_mod), 32'h0);
    check("hold_val", 32'(deser_data_val), 32'h0);

    repeat (2) drive(1'b0, 1'b0);
    check("pending_strobes", 32'(sb.size()), 32'd0);
    check("strobe_count", 32'(seen), 32'(pushed));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the parallel word width in bits.
REQ-002 The block SHALL have parameter MOD_W, default $clog2(DATA_W) (4), giving the width of the bit-count field.
REQ-003 The block SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port arst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port ser_data_i  input  1  serial data bit, sampled only when ser_data_val_i=1.
REQ-006 The block SHALL have port ser_data_val_i  input  1  qualifies ser_data_i; a contiguous run of 1s forms one word.
REQ-007 The block SHALL have port deser_data_o  output  DATA_W  recovered word, MSB-first, left-aligned.
REQ-008 The block SHALL have port deser_data_mod_o  output  MOD_W  valid bit count of deser_data_o, with 0 meaning DATA_W bits.
REQ-009 The block SHALL have port deser_data_val_o  output  1  one-cycle strobe qualifying deser_data_o and deser_data_mod_o.
REQ-010 The block SHALL have port busy_o  output  1  high while a word is being collected.

Function
REQ-011 The block SHALL implement a two-state FSM with states IDLE and RECV and a bit counter cnt of range 0..DATA_W.
- IDLE, ser_data_val_i=1: store the bit, set cnt=1, go to RECV.
- RECV, ser_data_val_i=1: store the bit, increment cnt.
REQ-012 The block SHALL store the first bit of a run in shift-register bit [DATA_W-1] and each later bit one position lower, MSB-first.
REQ-013 On the edge that samples the DATA_W-th bit, the block SHALL register deser_data_o, set deser_data_mod_o=0 and deser_data_val_o=1, set cnt=0, and go to IDLE.
REQ-014 On an edge in RECV with ser_data_val_i=0 and cnt>=3, the block SHALL register the partial word left-aligned with unused LSBs zero, set deser_data_mod_o=cnt, and pulse deser_data_val_o.
REQ-015 On an edge in RECV with ser_data_val_i=0 and cnt in {1,2}, the block SHALL discard the run, produce no strobe, and go to IDLE.
- Rationale: bit counts 1 and 2 are illegal word lengths.
REQ-016 deser_data_val_o SHALL be high for exactly one cycle per completed word.
- Latency: one cycle after the completing edge.
REQ-017 deser_data_o and deser_data_mod_o SHALL hold their last values while deser_data_val_o=0.
REQ-018 Valid bits continuing past DATA_W SHALL start a new word on the next valid cycle with no bit lost.
- For a word completed at edge N, a valid bit at edge N+1 becomes the MSB of the next word.
- The output strobe and the new word's start SHALL overlap without interference.
REQ-019 busy_o SHALL equal 1 exactly when the FSM is in RECV.
REQ-020 The shift register SHALL be cleared to zero at the start of each word, so no bits from a previous word leak into it.

Reset
REQ-021 When arst_n_i=0, the block SHALL immediately force FSM=IDLE, cnt=0, shift register=0, deser_data_o=0, deser_data_mod_o=0, deser_data_val_o=0, and busy_o=0, independent of clk_i.
REQ-022 A reset asserted mid-word SHALL abandon that word with no strobe.
- The first valid bit after deassertion starts a fresh word.
REQ-023 Reset deassertion SHALL be treated as synchronous to clk_i.
- The first valid bit is sampled on the first rising edge after arst_n_i returns to 1.

Verification
REQ-024 The bench SHALL check reset: arst_n_i pulsed low between clock edges -> all outputs 0 immediately, before the next edge.
REQ-025 The bench SHALL check a full word: 16 valid bits 1111_0000_1111_0000 then val=0 -> one cycle after the 16th bit, deser_data_o=16'hF0F0, deser_data_mod_o=0, deser_data_val_o=1 for one cycle.
REQ-026 The bench SHALL check a partial word: 5 valid bits 1,0,1,1,0 then val=0 -> deser_data_o=16'hB000, deser_data_mod_o=5, one strobe; busy_o high for 5 cycles.
REQ-027 The bench SHALL check a short run: 2 valid bits then val=0 -> no strobe, busy_o returns to 0, and the next 16-bit word is recovered correctly.
REQ-028 The bench SHALL check back-to-back words: 32 consecutive valid bits (16'hA5A5 then 16'h0FF0) -> two strobes 16 cycles apart with values A5A5 then 0FF0, both mod 0.
REQ-029 The bench SHALL check reset mid-word: arst_n_i low after 9 bits, then 16 fresh bits of 16'h1234 -> exactly one strobe, deser_data_o=16'h1234.
